// File: rtl/gbc_video_pkg.sv
// Shared types and constants for the GBC video memory block.
// No logic; referenced by the interface, the BRAM wrapper and the top.
// No flow control of its own.
package gbc_video_pkg;

  typedef enum logic [1:0] {
    TGA_VRAM = 2'b00,
    TGA_OAM  = 2'b01,
    TGA_REG  = 2'b10,
    TGA_RSVD = 2'b11
  } tga_e;

  typedef enum logic [1:0] {
    PPU_HBLANK   = 2'd0,
    PPU_VBLANK   = 2'd1,
    PPU_OAM_SCAN = 2'd2,
    PPU_DRAW     = 2'd3
  } ppu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_COPY = 2'd2
  } state_e;

  // Where the response byte comes from in the ACK cycle.
  typedef enum logic [1:0] {
    SRC_CONST = 2'd0,
    SRC_VRAM  = 2'd1,
    SRC_OAM   = 2'd2
  } resp_src_e;

  localparam int         OAM_BYTES_DEFAULT = 160;
  localparam logic [7:0] REG_DMA           = 8'h46;
  localparam logic [7:0] REG_VBK           = 8'h4F;
  localparam logic [7:0] OPEN_BUS          = 8'hFF;

endpackage

// File: rtl/gbc_video_memory_if.sv
// Wishbone pipelined link between the memory bus initiator and video memory.
// Response one cycle after accept (two for a VRAM-to-OAM copy).
// Target holds off new requests with STALL.
interface gbc_video_memory_if;
  import gbc_video_pkg::*;

  logic        CYC;
  logic        STB;
  logic        WE;
  logic [13:0] ADDR;
  tga_e        TGA;
  logic        TGC;
  logic [7:0]  DAT_I;
  logic [7:0]  DAT_O;
  logic        ACK;
  logic        STALL;

  modport master (
    output CYC, STB, WE, ADDR, TGA, TGC, DAT_I,
    input  DAT_O, ACK, STALL
  );

  modport slave (
    input  CYC, STB, WE, ADDR, TGA, TGC, DAT_I,
    output DAT_O, ACK, STALL
  );

endinterface

// File: rtl/gbc_video_dpram.sv
// True dual-port RAM, read-first; port A read/write, port B read-only.
// Read data registered: 1-cycle latency on both ports.
// No backpressure; both ports serve every cycle.
module gbc_video_dpram #(
  parameter string DeviceType = "Xilinx",
  parameter int    AddrWidth  = 8,
  parameter int    DataWidth  = 8
) (
  input  logic                 clk,
  input  logic                 a_we,
  input  logic [AddrWidth-1:0] a_addr,
  input  logic [DataWidth-1:0] a_wdata,
  output logic [DataWidth-1:0] a_rdata,
  input  logic [AddrWidth-1:0] b_addr,
  output logic [DataWidth-1:0] b_rdata
);

  localparam int Depth = 1 << AddrWidth;

  if (DeviceType == "Xilinx") begin : g_xilinx
    (* ram_style = "block" *) logic [DataWidth-1:0] mem [Depth];

    // Port A: old word out, then optional write (read-first).
    always_ff @(posedge clk) begin
      a_rdata <= mem[a_addr];
      if (a_we) mem[a_addr] <= a_wdata;
    end

    // Port B: read-only, sees the pre-write word on a collision.
    always_ff @(posedge clk) begin
      b_rdata <= mem[b_addr];
    end
  end else begin : g_generic
    logic [DataWidth-1:0] mem [Depth];

    // Port A: old word out, then optional write (read-first).
    always_ff @(posedge clk) begin
      a_rdata <= mem[a_addr];
      if (a_we) mem[a_addr] <= a_wdata;
    end

    // Port B: read-only, sees the pre-write word on a collision.
    always_ff @(posedge clk) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/gbc_video_memory.sv
// VRAM/OAM/register target for the memory bus plus always-served PPU read ports; PPU_ACCESS_LOCK_EN adds PPU-mode access locking.
// ACK one cycle after accept; VRAM-to-OAM copy ACKs two cycles after accept.
// STALL only during the copy cycle; PPU ports are never stalled.
module gbc_video_memory
  import gbc_video_pkg::*;
#(
  parameter string DeviceType = "Xilinx",
  parameter int    OamBytes   = OAM_BYTES_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  gbc_video_memory_if.slave wb,
  input  logic [1:0]        PpuMode,
  input  logic [13:0]       PpuVramAddr,
  output logic [7:0]        PpuVramData,
  input  logic [7:0]        PpuOamAddr,
  output logic [7:0]        PpuOamData
);

  state_e      state_q, state_d;
  resp_src_e   req_src, resp_src_q;
  logic [7:0]  req_byte, resp_byte_q;
  logic        vbk_q;
  logic [7:0]  dma_src_q;
  logic [7:0]  copy_idx_q;
  logic        accept, copy_req, stall, ack, in_copy, copy_wr, reg_we;
  logic        vram_we, oam_we_bus, oam_we;
  logic        vram_blocked, oam_blocked, oam_in_range;
  logic [7:0]  oam_addr, oam_wdata;
  logic [7:0]  vram_rdata, oam_rdata, ppu_vram_q, ppu_oam_q;
  logic [7:0]  resp_dat;

`ifdef PPU_ACCESS_LOCK_EN
  assign vram_blocked = (PpuMode == PPU_DRAW);
  assign oam_blocked  = (PpuMode == PPU_OAM_SCAN) || (PpuMode == PPU_DRAW);
`else
  logic unused_ppu_mode;
  assign unused_ppu_mode = ^PpuMode;
  assign vram_blocked    = 1'b0;
  assign oam_blocked     = 1'b0;
`endif

  assign in_copy      = (state_q == ST_COPY);
  assign stall        = in_copy && !RST;
  assign ack          = (state_q == ST_RESP) && wb.CYC && !RST;
  assign accept       = wb.CYC && wb.STB && !stall && !RST;
  // The copy write is abandoned if the cycle is dropped or reset hits.
  assign copy_wr      = in_copy && wb.CYC && !RST;
  assign oam_in_range = int'(wb.ADDR[7:0]) < OamBytes;
  assign reg_we       = accept && wb.WE && (wb.TGA == TGA_REG);

  // Decode an accepted request: response source/byte and BRAM write enables.
  always_comb begin
    req_src    = SRC_CONST;
    req_byte   = OPEN_BUS;
    vram_we    = 1'b0;
    oam_we_bus = 1'b0;
    copy_req   = 1'b0;
    if (accept) begin
      unique case (wb.TGA)
        TGA_VRAM: begin
          if (wb.TGC) begin
            copy_req = 1'b1;
          end else if (!vram_blocked) begin
            req_src = SRC_VRAM;
            vram_we = wb.WE;
          end
        end
        TGA_OAM: begin
          if (wb.TGC) begin
            oam_we_bus = 1'b1;
            req_byte   = wb.DAT_I;
          end else if (!oam_blocked && oam_in_range) begin
            req_src    = SRC_OAM;
            oam_we_bus = wb.WE;
          end
        end
        TGA_REG: begin
          if (wb.ADDR[7:0] == REG_VBK) begin
            req_byte = {7'h7F, vbk_q};
          end else if (wb.ADDR[7:0] == REG_DMA) begin
            req_byte = dma_src_q;
          end
        end
        default: ;
      endcase
    end
  end

  // OAM port A is shared between bus accesses and the copy write-back.
  assign oam_we    = oam_we_bus || copy_wr;
  assign oam_addr  = in_copy ? copy_idx_q : wb.ADDR[7:0];
  assign oam_wdata = in_copy ? vram_rdata : wb.DAT_I;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; RESP may accept again with no bubble.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) state_d = copy_req ? ST_COPY : ST_RESP;
        else        state_d = ST_IDLE;
      end
      ST_COPY: state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
    if (!wb.CYC) state_d = ST_IDLE;
  end

  // Response bookkeeping and the VBK / DMA source registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      resp_src_q  <= SRC_CONST;
      resp_byte_q <= 8'h00;
      vbk_q       <= 1'b0;
      dma_src_q   <= 8'h00;
      copy_idx_q  <= 8'h00;
    end else begin
      if (accept) begin
        resp_src_q  <= req_src;
        resp_byte_q <= req_byte;
        copy_idx_q  <= wb.ADDR[7:0];
      end else if (in_copy) begin
        resp_src_q  <= SRC_CONST;
        resp_byte_q <= vram_rdata;
      end
      if (reg_we && wb.ADDR[7:0] == REG_VBK) vbk_q     <= wb.DAT_I[0];
      if (reg_we && wb.ADDR[7:0] == REG_DMA) dma_src_q <= wb.DAT_I;
    end
  end

  // Response data mux; bus reads zero outside the ACK cycle.
  always_comb begin
    resp_dat = resp_byte_q;
    unique case (resp_src_q)
      SRC_VRAM: resp_dat = vram_rdata;
      SRC_OAM:  resp_dat = oam_rdata;
      default:  resp_dat = resp_byte_q;
    endcase
  end

  assign wb.DAT_O = ack ? resp_dat : 8'h00;
  assign wb.ACK   = ack;
  assign wb.STALL = stall;

  assign PpuVramData = RST ? 8'h00 : ppu_vram_q;
  assign PpuOamData  = RST ? 8'h00 : ppu_oam_q;

  gbc_video_dpram #(
    .DeviceType(DeviceType),
    .AddrWidth (14),
    .DataWidth (8)
  ) u_vram (
    .clk    (CLK),
    .a_we   (vram_we),
    .a_addr (wb.ADDR),
    .a_wdata(wb.DAT_I),
    .a_rdata(vram_rdata),
    .b_addr (PpuVramAddr),
    .b_rdata(ppu_vram_q)
  );

  gbc_video_dpram #(
    .DeviceType(DeviceType),
    .AddrWidth (8),
    .DataWidth (8)
  ) u_oam (
    .clk    (CLK),
    .a_we   (oam_we),
    .a_addr (oam_addr),
    .a_wdata(oam_wdata),
    .a_rdata(oam_rdata),
    .b_addr (PpuOamAddr),
    .b_rdata(ppu_oam_q)
  );

endmodule

// File: tb/tb_gbc_video_memory.sv
// Directed bench for gbc_video_memory with hand-computed expectations.
// Bus transfers are sampled 1 time unit after the rising edge.
// Each transfer waits a bounded number of cycles for ACK.
module tb_gbc_video_memory;
  import gbc_video_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ppu_mode;
  logic [13:0] ppu_vram_addr;
  logic [7:0]  ppu_vram_data;
  logic [7:0]  ppu_oam_addr;
  logic [7:0]  ppu_oam_data;
  int          n_checks = 0;
  int          n_errors = 0;

  gbc_video_memory_if bus();

  gbc_video_memory dut (
    .CLK        (clk),
    .RST        (rst),
    .wb         (bus),
    .PpuMode    (ppu_mode),
    .PpuVramAddr(ppu_vram_addr),
    .PpuVramData(ppu_vram_data),
    .PpuOamAddr (ppu_oam_addr),
    .PpuOamData (ppu_oam_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer starting at posedge+1; returns read data, ACK latency
  // in cycles (99 = no ACK) and number of cycles STALL was seen.
  task automatic wb_xfer(input tga_e tga, input logic tgc, input logic we,
                         input logic [13:0] addr, input logic [7:0] din,
                         output logic [7:0] dout, output int lat, output int stalls);
    bus.CYC   = 1'b1;
    bus.STB   = 1'b1;
    bus.WE    = we;
    bus.TGA   = tga;
    bus.TGC   = tgc;
    bus.ADDR  = addr;
    bus.DAT_I = din;
    @(posedge clk); #1;
    bus.STB = 1'b0;
    bus.WE  = 1'b0;
    lat     = 1;
    stalls  = 0;
    while (!bus.ACK && lat < 6) begin
      if (bus.STALL) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    dout = bus.DAT_O;
    if (!bus.ACK) lat = 99;
    bus.CYC = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int lat, st;

    rst = 1'b1;
    bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0; bus.TGA = TGA_VRAM;
    bus.TGC = 1'b0; bus.ADDR = '0; bus.DAT_I = '0;
    ppu_mode = 2'd0; ppu_vram_addr = '0; ppu_oam_addr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ack", bus.ACK, 0);
    check_val("rst_stall", bus.STALL, 0);
    check_val("rst_dat_o", bus.DAT_O, 8'h00);
    check_val("rst_ppu_vram", ppu_vram_data, 8'h00);
    check_val("rst_ppu_oam", ppu_oam_data, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // VRAM banking: bank 1 write must not disturb bank 0
    wb_xfer(TGA_VRAM, 0, 1, 14'h0010, 8'hA5, d, lat, st);
    wb_xfer(TGA_VRAM, 0, 1, 14'h2010, 8'h5A, d, lat, st);
    wb_xfer(TGA_VRAM, 0, 0, 14'h2010, 8'h00, d, lat, st);
    check_val("vram_b1_lat", lat, 1);
    check_val("vram_b1_dat", d, 8'h5A);
    @(posedge clk); #1;
    check_val("ack_one_cycle", bus.ACK, 0);
    wb_xfer(TGA_VRAM, 0, 0, 14'h0010, 8'h00, d, lat, st);
    check_val("vram_b0_dat", d, 8'hA5);

    // PPU VRAM port
    ppu_vram_addr = 14'h2010;
    @(posedge clk); #1;
    check_val("ppu_vram_rd", ppu_vram_data, 8'h5A);

    // OAM bound at OamBytes = 160
    wb_xfer(TGA_OAM, 0, 1, 14'h009F, 8'h33, d, lat, st);
    wb_xfer(TGA_OAM, 0, 1, 14'h00A0, 8'h44, d, lat, st);
    wb_xfer(TGA_OAM, 0, 0, 14'h009F, 8'h00, d, lat, st);
    check_val("oam_9f", d, 8'h33);
    wb_xfer(TGA_OAM, 0, 0, 14'h00A0, 8'h00, d, lat, st);
    check_val("oam_a0", d, 8'hFF);

    // VRAM-sourced OAM DMA copy
    wb_xfer(TGA_VRAM, 0, 1, 14'h0005, 8'h77, d, lat, st);
    wb_xfer(TGA_VRAM, 1, 0, 14'h0005, 8'h00, d, lat, st);
    check_val("copy_stalls", st, 1);
    check_val("copy_lat", lat, 2);
    check_val("copy_dat", d, 8'h77);
    ppu_oam_addr = 8'd5;
    @(posedge clk); #1;
    check_val("copy_ppu_oam", ppu_oam_data, 8'h77);

    // Access lock in draw mode
    wb_xfer(TGA_VRAM, 0, 1, 14'h0001, 8'h22, d, lat, st);
    ppu_mode = 2'd3;
    wb_xfer(TGA_VRAM, 0, 1, 14'h0001, 8'h11, d, lat, st);
    check_val("lock_wr_lat", lat, 1);
`ifdef PPU_ACCESS_LOCK_EN
    check_val("lock_wr_dat", d, 8'hFF);
    ppu_mode = 2'd0;
    wb_xfer(TGA_VRAM, 0, 0, 14'h0001, 8'h00, d, lat, st);
    check_val("lock_vram_kept", d, 8'h22);
    ppu_mode = 2'd3;
`else
    wb_xfer(TGA_VRAM, 0, 0, 14'h0001, 8'h00, d, lat, st);
    check_val("nolock_vram_wr", d, 8'h11);
`endif
    wb_xfer(TGA_OAM, 1, 1, 14'h0001, 8'h11, d, lat, st);
    check_val("ext_dma_dat", d, 8'h11);
    ppu_oam_addr = 8'd1;
    @(posedge clk); #1;
    check_val("ext_dma_oam", ppu_oam_data, 8'h11);
    ppu_mode = 2'd0;

    // Register space and reserved space
    wb_xfer(TGA_REG, 0, 1, 14'h004F, 8'h01, d, lat, st);
    wb_xfer(TGA_REG, 0, 0, 14'h004F, 8'h00, d, lat, st);
    check_val("vbk_1", d, 8'hFF);
    wb_xfer(TGA_REG, 0, 1, 14'h004F, 8'h00, d, lat, st);
    wb_xfer(TGA_REG, 0, 0, 14'h004F, 8'h00, d, lat, st);
    check_val("vbk_0", d, 8'hFE);
    wb_xfer(TGA_REG, 0, 1, 14'h0046, 8'hC3, d, lat, st);
    wb_xfer(TGA_REG, 0, 0, 14'h0046, 8'h00, d, lat, st);
    check_val("dma_src", d, 8'hC3);
    wb_xfer(TGA_REG, 0, 1, 14'h0040, 8'h12, d, lat, st);
    wb_xfer(TGA_REG, 0, 0, 14'h0040, 8'h00, d, lat, st);
    check_val("reg_40", d, 8'hFF);
    wb_xfer(TGA_RSVD, 0, 0, 14'h0003, 8'h00, d, lat, st);
    check_val("rsvd_dat", d, 8'hFF);
    check_val("rsvd_lat", lat, 1);

    // Read-first collision between bus write and PPU read
    wb_xfer(TGA_VRAM, 0, 1, 14'h0030, 8'h10, d, lat, st);
    ppu_vram_addr = 14'h0030;
    wb_xfer(TGA_VRAM, 0, 1, 14'h0030, 8'h20, d, lat, st);
    check_val("rdfirst_old", ppu_vram_data, 8'h10);
    @(posedge clk); #1;
    check_val("rdfirst_new", ppu_vram_data, 8'h20);

    // Reset during copy
    wb_xfer(TGA_OAM, 0, 1, 14'h0007, 8'h99, d, lat, st);
    wb_xfer(TGA_VRAM, 0, 1, 14'h0007, 8'h55, d, lat, st);
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b0;
    bus.TGA = TGA_VRAM; bus.TGC = 1'b1; bus.ADDR = 14'h0007;
    @(posedge clk); #1;
    bus.STB = 1'b0;
    check_val("rstcopy_stall_pre", bus.STALL, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rstcopy_ack", bus.ACK, 0);
    check_val("rstcopy_stall", bus.STALL, 0);
    rst = 1'b0;
    bus.CYC = 1'b0;
    bus.TGC = 1'b0;
    @(posedge clk); #1;
    check_val("rstcopy_ack_after", bus.ACK, 0);
    wb_xfer(TGA_OAM, 0, 0, 14'h0007, 8'h00, d, lat, st);
    check_val("rstcopy_oam_kept", d, 8'h99);
    check_val("rstcopy_follow_lat", lat, 1);
    wb_xfer(TGA_VRAM, 0, 0, 14'h0007, 8'h00, d, lat, st);
    check_val("rstcopy_vram", d, 8'h55);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gbc_video_memory.md
GBC_VIDEO_MEMORY -- requirements
Module: gbc_video_memory

Interface
REQ-001 SHALL have parameter DeviceType, default "Xilinx", selecting the BRAM inference style.
REQ-002 SHALL have parameter OamBytes, default 160, giving the number of OAM entries.
REQ-003 SHALL have port CLK, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port RST, input, 1, the reset, synchronous and active-high.
REQ-005 SHALL have ports CYC/STB/WE, input, 1 each: the Wishbone pipelined target strobes from the GBCMemoryBus VideoRAM initiator.
REQ-006 SHALL have port ADDR, input, 14: bit 13 is the VRAM bank, bits 12:0 are the offset; OAM and register spaces use bits 7:0.
REQ-007 SHALL have port TGA, input, 2: 00 VRAM, 01 OAM, 10 registers, 11 reserved.
REQ-008 SHALL have port TGC, input, 1: 0 regular access, 1 OAM-DMA access.
REQ-009 SHALL have ports DAT_I, input, 8, and DAT_O, output, 8, for write and read data.
REQ-010 SHALL have ports ACK and STALL, output, 1 each, for the Wishbone response and flow control.
REQ-011 SHALL have port PpuMode, input, 2: 0 HBlank, 1 VBlank, 2 OAM scan, 3 draw.
REQ-012 SHALL have ports PpuVramAddr, input, 14, and PpuVramData, output, 8, forming the PPU VRAM read port with 1-cycle latency.
REQ-013 SHALL have ports PpuOamAddr, input, 8, and PpuOamData, output, 8, forming the PPU OAM read port with 1-cycle latency.

Function
REQ-014 SHALL accept a request on any cycle where CYC&STB&!STALL, and SHALL assert ACK for exactly one cycle on the next cycle, with DAT_O valid while ACK is high.
REQ-015 SHALL give regular VRAM access (TGA=00, TGC=0) read or write of 16 KiB at ADDR[13:0].
REQ-016 SHALL give regular OAM access (TGA=01, TGC=0) read or write at ADDR[7:0] when the index is below OamBytes; at or above OamBytes, reads return 0xFF and writes are dropped.
REQ-017 SHALL decode the register space (TGA=10) as follows: offset 0x4F (VBK) reads {7'h7F, last VBK written bit 0}; offset 0x46 reads the last DMA source byte written; all other offsets read 0xFF with writes ignored.
REQ-018 SHALL treat a TGA=11 access as read 0xFF with the write dropped, ACKed normally.
REQ-019 SHALL, for an external OAM-DMA write (TGA=01, TGC=1), write DAT_I to OAM[ADDR[7:0]] regardless of PpuMode, return DAT_I on DAT_O, and ACK.
REQ-020 SHALL, for a VRAM-sourced OAM DMA (TGA=00, TGC=1), read VRAM[ADDR] and then write that byte to OAM[ADDR[7:0]]; ACK comes 2 cycles after acceptance, DAT_O is the copied byte, and STALL is high during the copy cycle.
REQ-021 SHALL implement the state machine IDLE -> RESP (single-cycle access) -> IDLE; IDLE -> COPY (REQ-020) -> RESP -> IDLE; back-to-back accepts from RESP are allowed, so there is no bubble.
REQ-022 SHALL assert STALL only in COPY; a request presented in COPY is held off and accepted in RESP.
REQ-023 SHALL drop any pending ACK and return to IDLE when CYC falls; a BRAM write already issued completes.
REQ-024 SHALL give the PPU read ports priority-free, always-served access via the second BRAM port, never stalled by Wishbone traffic.
REQ-025 SHALL resolve same-address same-cycle Wishbone write and PPU read as read-first: the PPU sees the old data.

Reset
REQ-026 SHALL, while RST is high, force ACK=0, STALL=0, DAT_O=0x00, state=IDLE, VBK=0 and the DMA source byte=0x00, and discard any request in flight.
REQ-027 SHALL leave BRAM contents unchanged by reset, while the PPU data outputs hold 0x00 during reset.

Configuration
REQ-028 SHALL, with PPU_ACCESS_LOCK_EN defined, block regular (TGC=0) accesses as follows: VRAM is blocked in PpuMode 3 and OAM in PpuMode 2 or 3; a blocked access reads 0xFF, drops its write, and is still ACKed at the normal latency.
REQ-029 SHALL, without PPU_ACCESS_LOCK_EN, never block accesses and ignore PpuMode.

Structure
REQ-030 SHALL place the TGA space enum, the PpuMode enum, the OamBytes default and the register offsets 0x46/0x4F in the shared package gbc_video_pkg.
REQ-031 SHALL instantiate the sub-module gbc_video_dpram (true dual-port BRAM, read-first, DeviceType-parameterised) twice: once for VRAM and once for OAM.

Verification
REQ-032 SHALL be verified by: write VRAM 0x0010=0x5A with VBK-bank ADDR[13]=1, then read 0x2010 -> ACK next cycle, DAT_O=0x5A; read 0x0010 -> DAT_O unchanged (prior value).
REQ-033 SHALL be verified by: OAM write index 0x9F=0x33 then 0xA0=0x44, then read both -> 0x33 and 0xFF.
REQ-034 SHALL be verified by: VRAM 0x0005=0x77, then a TGC=1 TGA=00 access with ADDR=0x0005 -> STALL for 1 cycle, ACK at +2, DAT_O=0x77, and PPU OAM read of index 5 = 0x77.
REQ-035 SHALL be verified by: with PPU_ACCESS_LOCK_EN and PpuMode=3, a regular VRAM write 0x0001=0x11 -> ACK, DAT_O=0xFF, memory unchanged; the same access with TGC=1 on TGA=01 writes OAM successfully.
REQ-036 SHALL be verified by: write 0x01 to register 0x4F and read it back -> 0xFF; register 0x40 -> 0xFF; TGA=11 -> 0xFF.
REQ-037 SHALL be verified by: asserting RST during COPY -> next cycle ACK=0, STALL=0, and OAM not written; a follow-up access behaves normally.
